// File: rtl/mwadd_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package mwadd_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/ripple_carry_16_bit.sv
// 16-bit ripple-carry adder; the single adder time-shared across all chunks.
module ripple_carry_16_bit
  import mwadd_pkg::*;
(
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               c_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);

  logic c;

  always_comb begin
    sum_o = '0;
    c     = c_i;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// WORDS x 16-bit add/subtract, one chunk per cycle through a shared adder,
// LSB chunk first, with valid/ready handshakes on operands and result.
module multiword_add_sequencer
  import mwadd_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CHUNK = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHUNK_W*WORDS-1:0]   a,
  input  logic [CHUNK_W*WORDS-1:0]   b,
  input  logic                       cin,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHUNK_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int W     = CHUNK_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  if (CHUNK != CHUNK_W) begin : g_bad_chunk
    $error("multiword_add_sequencer: CHUNK must be 16");
  end
  if (WORDS < 2) begin : g_bad_words
    $error("multiword_add_sequencer: WORDS must be at least 2");
  end

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;      // already inverted for subtract
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK_W-1:0] add_a, add_b, add_sum;
  logic               add_cout;

  assign add_a = a_q[idx_q*CHUNK_W +: CHUNK_W];
  assign add_b = b_q[idx_q*CHUNK_W +: CHUNK_W];

  ripple_carry_16_bit u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .c_i    (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK_W +: CHUNK_W] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Overflow uses the top chunk's sum bit, i.e. the full-width MSB.
          state_d = DONE;
          idx_d   = '0;
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[CHUNK_W-1] != a_q[W-1]);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand holding registers carry no reset; they are loaded on every accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with an arithmetic reference model.
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  multiword_add_sequencer #(.WORDS(WORDS), .CHUNK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic ov_prev = 1'b0;
  res_t         mq[$];
  int           acc_log[$];
  logic [W-1:0] res_log[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    res_t r;
    logic [W-1:0] be;
    logic [W:0]   full;
    be   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + ((ms ? 1'b1 : mc) ? {{W{1'b0}}, 1'b1} : '0);
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.v  = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
    return r;
  endfunction

  // Monitor: track accepts, results leaving, and resets at each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
    end else begin
      if (out_valid && out_ready) begin
        res_log.push_back(sum);
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (in_valid && in_ready) begin
        mq.push_back(model(a, b, cin, sub));
        acc_cyc = cyc;
        acc_log.push_back(cyc);
      end
    end
  end

  // Compare: every cycle the result is presented, check it against the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (mq.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        chk("model_sum", sum, mq[0].s);
        chk("model_cout", W'(cout), W'(mq[0].c));
        chk("model_ovf", W'(ovf), W'(mq[0].v));
      end
      if (!ov_prev) chk("latency", W'(cyc - acc_cyc), W'(WORDS));
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input logic ts);
    int n;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", W'(out_valid), 1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    send(ta, tb_, tc, ts);
    wait_out();
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, W'(cout), W'(ec));
    chk({name, "_ovf"}, W'(ovf), W'(ev));
    @(negedge clk);
  endtask

  logic [W-1:0] ops_a[3];
  logic [W-1:0] ops_b[3];
  logic         ops_c[3];
  logic [W-1:0] ops_e[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", W'(cout), 0);
    chk("rst_ovf", W'(ovf), 0);

    run_op("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("borrow", 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("sub_5_3", 64'd5, 64'd3, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum", sum, 64'h1234_5678_9ABC_DF01);
      chk("bp_cout", W'(cout), 0);
      chk("bp_ovf", W'(ovf), 0);
      chk("bp_out_valid", W'(out_valid), 1);
      chk("bp_in_ready", W'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", W'(in_ready), 1);
    chk("bp_release_out_valid", W'(out_valid), 0);

    // Reset after two chunk cycles discards the operation.
    send(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_in_ready", W'(in_ready), 1);
    chk("midrun_out_valid", W'(out_valid), 0);
    chk("midrun_sum", sum, 0);
    run_op("after_rst", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

    // Back-to-back with in_valid held high.
    ops_a[0] = 64'd10;             ops_b[0] = 64'd20;             ops_c[0] = 1'b1;
    ops_e[0] = 64'd31;
    ops_a[1] = 64'h0000_0000_0000_FFFF; ops_b[1] = 64'd1;         ops_c[1] = 1'b0;
    ops_e[1] = 64'h0000_0000_0001_0000;
    ops_a[2] = 64'h0000_0001_0000_0000; ops_b[2] = 64'h0000_0002_0000_0000; ops_c[2] = 1'b1;
    ops_e[2] = 64'h0000_0003_0000_0001;
    acc_log.delete();
    res_log.delete();
    sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      a = ops_a[i]; b = ops_b[i]; cin = ops_c[i];
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk("b2b_accept_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 100 && res_log.size() < 3; n++) @(negedge clk);
    chk("b2b_accepts", W'(acc_log.size()), 3);
    chk("b2b_results", W'(res_log.size()), 3);
    if (acc_log.size() == 3) begin
      chk("b2b_interval0", W'(acc_log[1] - acc_log[0]), W'(WORDS + 2));
      chk("b2b_interval1", W'(acc_log[2] - acc_log[1]), W'(WORDS + 2));
    end
    if (res_log.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_result", res_log[i], ops_e[i]);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
